// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between picorv32 and the GPU pixel reader, forwarding
// CPU accesses at or above MEM_SIZE to an MMIO port; the GPU has priority, but CPU starvation is bounded.
module mem_arbiter #(
  parameter int MEM_SIZE     = 24576,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = $clog2(MEM_SIZE/4),
  localparam int SW = $clog2(STARVE_LIMIT+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_valid,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  input  logic          gpu_MemRead,
  input  logic [31:0]   gpu_MemAddr,
  output logic [15:0]   gpu_MemData,
  output logic          gpu_MemValid,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_wstrb,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          io_valid,
  output logic [31:0]   io_addr,
  output logic [31:0]   io_wdata,
  output logic [3:0]    io_wstrb,
  input  logic          io_ready,
  input  logic [31:0]   io_rdata
);
  typedef enum logic [2:0] {IDLE, GPU_ISSUE, GPU_WAIT, CPU_ISSUE, CPU_WAIT, CPU_IO, RESP} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d, gpu_q, gpu_d;
  logic [31:0] paddr_q, paddr_d, addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [SW-1:0] streak_q, streak_d;
  logic gpu_req, cpu_elig, gpu_win, in_ram;
  logic [31:0] gpu_addr;
  assign gpu_req  = gpu_MemRead | pend_q;
  assign gpu_addr = gpu_MemRead ? gpu_MemAddr : paddr_q;
  assign cpu_elig = cpu_valid & ~cpu_ready;
  assign gpu_win  = gpu_req & ~(cpu_elig & (streak_q == SW'(STARVE_LIMIT)));
  assign in_ram   = addr_q < 32'(MEM_SIZE);
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | gpu_MemRead;
    paddr_d  = gpu_MemRead ? gpu_MemAddr : paddr_q;
    gpu_d    = gpu_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (gpu_win) begin
          state_d = GPU_ISSUE;
          gpu_d   = 1'b1;
          addr_d  = gpu_addr;
          pend_d  = 1'b0;
          if (cpu_elig && streak_q != SW'(STARVE_LIMIT)) streak_d = streak_q + 1'b1;
        end else if (cpu_elig) begin
          state_d  = (cpu_addr < 32'(MEM_SIZE)) ? CPU_ISSUE : CPU_IO;
          gpu_d    = 1'b0;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          wstrb_d  = cpu_wstrb;
          streak_d = '0;
        end
      end
      GPU_ISSUE: state_d = GPU_WAIT;
      GPU_WAIT: begin
        rdata_d = !in_ram ? 32'h0 : {16'h0, addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
        state_d = RESP;
      end
      CPU_ISSUE: begin
        rdata_d = 32'h0;
        state_d = |wstrb_q ? RESP : CPU_WAIT;
      end
      CPU_WAIT: begin
        rdata_d = ram_rdata;
        state_d = RESP;
      end
      CPU_IO: if (io_ready) begin
        rdata_d = |wstrb_q ? 32'h0 : io_rdata;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      paddr_q  <= '0;
      gpu_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      paddr_q  <= paddr_d;
      gpu_q    <= gpu_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      streak_q <= streak_d;
    end
  end
  // Data outputs are gated so every output reads zero outside its own strobe.
  assign gpu_MemValid = state_q == RESP && gpu_q;
  assign cpu_ready    = state_q == RESP && !gpu_q;
  assign gpu_MemData  = gpu_MemValid ? rdata_q[15:0] : 16'h0;
  assign cpu_rdata    = cpu_ready ? rdata_q : 32'h0;
  assign ram_en       = (state_q == GPU_ISSUE && in_ram) || state_q == CPU_ISSUE;
  assign ram_addr     = ram_en ? addr_q[AW+1:2] : '0;
  assign ram_wstrb    = state_q == CPU_ISSUE ? wstrb_q : 4'h0;
  assign ram_wdata    = state_q == CPU_ISSUE ? wdata_q : 32'h0;
  assign io_valid     = state_q == CPU_IO;
  assign io_addr      = io_valid ? addr_q - 32'(MEM_SIZE) : 32'h0;
  assign io_wdata     = io_valid ? wdata_q : 32'h0;
  assign io_wstrb     = io_valid ? wstrb_q : 4'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, routing, latency and reset behaviour.
module tb_mem_arbiter;
  logic clk = 0, reset = 1;
  logic cpu_valid = 0, gpu_MemRead = 0, io_ready = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, gpu_MemAddr = 0, io_rdata = 0, ram_rdata = 0;
  logic [3:0] cpu_wstrb = 0;
  logic cpu_ready, gpu_MemValid, ram_en, io_valid;
  logic [31:0] cpu_rdata, ram_wdata, io_addr, io_wdata;
  logic [15:0] gpu_MemData;
  logic [12:0] ram_addr;
  logic [3:0] ram_wstrb, io_wstrb;
  logic [31:0] mem [0:6143];
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .gpu_MemRead(gpu_MemRead), .gpu_MemAddr(gpu_MemAddr), .gpu_MemData(gpu_MemData), .gpu_MemValid(gpu_MemValid),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_ready(io_ready), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) begin
    ram_rdata <= mem[ram_addr];
    for (int b = 0; b < 4; b++) if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{cpu_ready, cpu_rdata, gpu_MemData, gpu_MemValid, ram_en, ram_addr, ram_wstrb, ram_wdata,
             io_valid, io_addr, io_wdata, io_wstrb};
  endfunction

  task automatic gpu_read(input logic [31:0] a, input logic [15:0] d, input logic en);
    gpu_MemRead = 1; gpu_MemAddr = a;
    @(negedge clk); gpu_MemRead = 0;
    chk("gpu_ram_en_t1", ram_en, en);
    if (en) chk("gpu_ram_addr_t1", ram_addr, a[14:2]);
    @(negedge clk); chk("gpu_valid_t2", gpu_MemValid, 0);
    @(negedge clk); chk("gpu_valid_t3", gpu_MemValid, 1); chk("gpu_data_t3", gpu_MemData, d);
    @(negedge clk); chk("gpu_valid_t4", gpu_MemValid, 0);
  endtask

  initial begin
    int ng, na, v, ren;
    bit seen;
    for (int i = 0; i < 6144; i++) mem[i] = 0;
    mem[32'h40] = 32'hAAAA5555;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", any_out(), 0);
    reset = 0;
    @(negedge clk);
    gpu_read(32'h0102, 16'hAAAA, 1);
    gpu_read(32'h0100, 16'h5555, 1);
    gpu_read(32'h6002, 16'h0000, 0);
    // store then load at 0x40 (word 0x10)
    cpu_valid = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'hF;
    @(negedge clk); chk("sw_ram_en_t1", ram_en, 1); chk("sw_wstrb_t1", ram_wstrb, 4'hF);
    chk("sw_ram_addr_t1", ram_addr, 32'h10); chk("sw_ready_t1", cpu_ready, 0);
    @(negedge clk); chk("sw_ready_t2", cpu_ready, 1); chk("sw_rdata_t2", cpu_rdata, 0); cpu_valid = 0;
    @(negedge clk); chk("sw_ready_t3", cpu_ready, 0);
    cpu_valid = 1; cpu_wstrb = 0;
    @(negedge clk); chk("lw_ram_en_t1", ram_en, 1); chk("lw_wstrb_t1", ram_wstrb, 0);
    @(negedge clk); chk("lw_ready_t2", cpu_ready, 0);
    @(negedge clk); chk("lw_ready_t3", cpu_ready, 1); chk("lw_rdata_t3", cpu_rdata, 32'hDEADBEEF); cpu_valid = 0;
    @(negedge clk); chk("lw_ready_t4", cpu_ready, 0);
    // simultaneous CPU and GPU request
    cpu_valid = 1; gpu_MemRead = 1; gpu_MemAddr = 32'h0100;
    @(negedge clk); gpu_MemRead = 0;
    @(negedge clk);
    @(negedge clk); chk("sim_gpu_first", gpu_MemValid, 1); chk("sim_cpu_waits", cpu_ready, 0);
    repeat (3) @(negedge clk);
    chk("sim_cpu_not_early", cpu_ready, 0);
    @(negedge clk); chk("sim_cpu_ready_t7", cpu_ready, 1); chk("sim_cpu_rdata", cpu_rdata, 32'hDEADBEEF); cpu_valid = 0;
    @(negedge clk);
    // starvation bound: continuous GPU requests with a waiting CPU load
    ng = 0; na = 0; seen = 0;
    cpu_valid = 1; gpu_MemRead = 1; gpu_MemAddr = 32'h0102;
    for (int i = 0; i < 60 && na == 0; i++) begin
      @(negedge clk);
      if (gpu_MemValid) begin if (seen) na++; else ng++; end
      if (cpu_ready) begin
        seen = 1;
        chk("starve_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_valid = 0;
      end
    end
    gpu_MemRead = 0;
    chk("starve_gpu_grants", ng, 4);
    chk("starve_cpu_served", 32'(seen), 1);
    chk("starve_gpu_resumed", na, 1);
    repeat (12) @(negedge clk);
    // MMIO write with io_ready delayed
    cpu_valid = 1; cpu_addr = 32'h6020; cpu_wdata = 32'h12345678; cpu_wstrb = 4'hF;
    v = 0; ren = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      v += int'(io_valid); ren += int'(ram_en);
      if (k == 1) begin
        chk("io_addr", io_addr, 32'h20); chk("io_wdata", io_wdata, 32'h12345678); chk("io_wstrb", io_wstrb, 4'hF);
      end
    end
    io_ready = 1;
    @(negedge clk); io_ready = 0;
    ren += int'(ram_en);
    chk("io_valid_held", v, 5); chk("io_no_ram_en", ren, 0);
    chk("io_valid_fell", io_valid, 0); chk("io_cpu_ready", cpu_ready, 1); cpu_valid = 0;
    @(negedge clk); chk("io_ready_once", cpu_ready, 0);
    // MMIO read, accepted immediately
    cpu_valid = 1; cpu_addr = 32'h6004; cpu_wstrb = 0; io_ready = 1; io_rdata = 32'h5A5A1234;
    @(negedge clk); chk("ior_valid_t1", io_valid, 1); chk("ior_addr", io_addr, 32'h4);
    @(negedge clk); io_ready = 0;
    chk("ior_ready_t2", cpu_ready, 1); chk("ior_rdata", cpu_rdata, 32'h5A5A1234); cpu_valid = 0;
    @(negedge clk);
    // reset while in GPU_WAIT
    gpu_MemRead = 1; gpu_MemAddr = 32'h0102;
    @(negedge clk); gpu_MemRead = 0;
    @(negedge clk); reset = 1;
    @(negedge clk); chk("rst_no_valid", gpu_MemValid, 0); chk("rst_outputs_zero", any_out(), 0);
    reset = 0; v = 0;
    repeat (4) begin @(negedge clk); v += int'(gpu_MemValid); end
    chk("rst_dropped", v, 0);
    gpu_read(32'h0100, 16'h5555, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port shared-RAM arbiter and address decoder between the picorv32 native memory bus and the GraphicSystem GPU read port. It serialises CPU fetches, loads and stores and GPU 16-bit pixel reads onto one synchronous RAM port, giving the GPU priority with bounded CPU starvation. CPU accesses at or above MEM_SIZE are forwarded to an MMIO port that carries the GPU control/status registers.

## Interface
- MEM_SIZE, 24576: RAM size in bytes; also the MMIO base address.
- STARVE_LIMIT, 4: maximum number of consecutive GPU grants while a CPU request waits.
- clk  in  1  system clock (the GraphicSystem cpuClk domain).
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  picorv32 mem_valid.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_wstrb  in  4  byte write enables; 0 means read.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_ready is high.
- gpu_MemRead  in  1  one-cycle read request pulse.
- gpu_MemAddr  in  32  byte address; bit 1 selects the halfword.
- gpu_MemData  out  16  read halfword, valid while gpu_MemValid is high.
- gpu_MemValid  out  1  one-cycle response pulse.
- ram_en  out  1  RAM access enable.
- ram_addr  out  $clog2(MEM_SIZE/4)  word address.
- ram_wstrb  out  4  byte write enables.
- ram_wdata  out  32  write data.
- ram_rdata  in  32  read data, valid the cycle after ram_en.
- io_valid  out  1  MMIO request, held until accepted.
- io_addr  out  32  address minus MEM_SIZE.
- io_wdata  out  32  MMIO write data.
- io_wstrb  out  4  MMIO byte write enables.
- io_ready  in  1  MMIO accept.
- io_rdata  in  32  MMIO read data, valid together with io_ready.

## Operation
- States:
  - IDLE: decide the grant.
  - GPU_ISSUE → GPU_WAIT → RESP: GPU read path.
  - CPU_ISSUE → CPU_WAIT → RESP: CPU RAM read path.
  - CPU_ISSUE → RESP: CPU RAM write path.
  - CPU_IO → RESP: CPU MMIO path.
  - RESP always returns to IDLE.
- One transaction is in flight at a time. There is no pipelining.
- GPU request capture:
  - gpu_MemRead latches gpu_MemAddr into a pending register in any state.
  - A newer request overwrites an unissued pending one.
- CPU eligibility: cpu_valid is high and cpu_ready is low in that cycle. This prevents re-servicing a request still asserted during its completion pulse.
- Arbitration in IDLE:
  - Pending GPU request wins, unless streak == STARVE_LIMIT and the CPU is eligible; then the CPU wins.
  - streak increments on each GPU grant made while the CPU is eligible.
  - streak clears on every CPU grant.
  - streak saturates at STARVE_LIMIT.
- Routing:
  - CPU addr < MEM_SIZE goes to RAM. ram_addr = addr[..:2]; ram_wstrb = cpu_wstrb.
  - CPU addr ≥ MEM_SIZE goes to MMIO.
  - GPU addr ≥ MEM_SIZE returns 16'h0000 with normal latency and no ram_en.
- gpu_MemData = addr[1] ? rdata[31:16] : rdata[15:0], registered.
- CPU writes return cpu_rdata = 0.

## Timing
- Cycle T is the cycle in which the request is seen in IDLE.
- GPU read:
  - ram_en high in T+1.
  - gpu_MemValid high in T+3 for exactly one cycle.
- CPU RAM read: ram_en in T+1; cpu_ready with cpu_rdata in T+3.
- CPU RAM write: ram_en with ram_wstrb in T+1; cpu_ready in T+2.
- CPU MMIO:
  - io_valid is registered and rises in T+1.
  - io_valid falls in the cycle after io_ready is sampled high.
  - cpu_ready and cpu_rdata = io_rdata (captured) follow one cycle after io_ready.
  - No timeout.
- Next grant can be decided in the RESP cycle's following IDLE cycle.
- ram_en, io_valid, cpu_ready and gpu_MemValid are never high for more than one cycle per transaction, except io_valid.
- Reset:
  - All outputs are 0 the cycle after reset is sampled high.
  - State returns to IDLE; pending and streak clear.
  - An in-flight transaction is dropped with no response pulse.
- Simultaneous CPU and GPU requests in IDLE: the GPU wins, per the streak rule.
- gpu_MemRead during RESP of a GPU transaction is pending and is serviced at the next IDLE.

## Test plan
- GPU read at 0x0102 with RAM word 0xAAAA5555 → gpu_MemValid 3 cycles later with gpu_MemData = 0xAAAA; address 0x0100 → 0x5555.
- CPU sw 0xDEADBEEF to 0x40, then lw from 0x40 → ram_wstrb = 4'hF in T+1 and cpu_ready in T+2; then cpu_rdata = 0xDEADBEEF in T+3. Exactly one ready per request.
- CPU and GPU request in the same cycle → GPU granted first; CPU cpu_ready follows after the GPU response.
- Back-to-back GPU requests with CPU waiting, STARVE_LIMIT = 4 → exactly 4 GPU grants, then the CPU is granted, then the GPU resumes.
- CPU sw to MEM_SIZE+0x20 with io_ready delayed 5 cycles → io_addr = 0x20, io_valid held 5 cycles, cpu_ready one cycle after io_ready; no ram_en.
- Reset asserted in GPU_WAIT → no gpu_MemValid; all outputs 0; a fresh request after reset completes with 3-cycle latency.
